// File: rtl/clusterv_wb_arb_pkg.sv
// clusterv_wb_arb_pkg: shared types and helpers for the cluster Wishbone arbiter.
// Holds the FSM encoding, the round-robin pick function and watchdog sizing.
package clusterv_wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int RR_MAX      = 8;
    localparam int TIMEOUT_DEF = 255;
    localparam int WD_W_DEF    = $clog2(TIMEOUT_DEF + 1);

    // Counter width able to hold TIMEOUT-1; a disabled watchdog keeps 1 bit.
    function automatic int wd_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    // One-hot grant: first set bit of req searching upward from last+1,
    // wrapping modulo n. Zero when nothing requests.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0] req,
        input int                last,
        input int                n
    );
        logic [RR_MAX-1:0] g;
        logic [2:0]        idx;
        g = '0;
        for (int k = 1; k <= RR_MAX; k++) begin
            idx = 3'((last + k) % n);
            if (k <= n && g == '0 && req[idx]) begin
                g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/clusterv_wb_arbiter_rr_pick.sv
// clusterv_rr_pick: combinational round-robin priority encoder.
// Also used by the cluster interrupt router.
module clusterv_rr_pick
    import clusterv_wb_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  gnt_nxt
);

    logic [RR_MAX-1:0] req_ext;
    logic [RR_MAX-1:0] pick;
    logic              pick_unused;

    // Widen to the package width, pick, then narrow back.
    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        pick           = rr_pick(req_ext, int'(last), N);
        gnt_nxt        = pick[N-1:0];
    end

    assign pick_unused = ^pick;

endmodule

// File: rtl/clusterv_wb_arbiter.sv
// clusterv_wb_arbiter: round-robin Wishbone arbiter with cycle lock
// and a per-transfer watchdog that terminates hung accesses with err.
module clusterv_wb_arbiter
    import clusterv_wb_arb_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int ADR_W     = 32,
    parameter int DAT_W     = 32,
    parameter int TGA_W     = 1,
    parameter int TGC_W     = 1,
    parameter int TGD_W     = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_MASTERS*ADR_W-1:0]     m_adr,
    input  logic [N_MASTERS*DAT_W-1:0]     m_dat_w,
    input  logic [N_MASTERS*(DAT_W/8)-1:0] m_sel,
    input  logic [N_MASTERS-1:0]           m_we,
    input  logic [N_MASTERS-1:0]           m_cyc,
    input  logic [N_MASTERS-1:0]           m_stb,
    input  logic [N_MASTERS*TGA_W-1:0]     m_tga,
    input  logic [N_MASTERS*TGC_W-1:0]     m_tgc,
    input  logic [N_MASTERS*TGD_W-1:0]     m_tgd_w,
    output logic [DAT_W-1:0]               m_dat_r,
    output logic [TGD_W-1:0]               m_tgd_r,
    output logic [N_MASTERS-1:0]           m_ack,
    output logic [N_MASTERS-1:0]           m_err,
    output logic [ADR_W-1:0]               s_adr,
    output logic [DAT_W-1:0]               s_dat_w,
    output logic [DAT_W/8-1:0]             s_sel,
    output logic                           s_we,
    output logic                           s_cyc,
    output logic                           s_stb,
    output logic [TGA_W-1:0]               s_tga,
    output logic [TGC_W-1:0]               s_tgc,
    output logic [TGD_W-1:0]               s_tgd_w,
    input  logic [DAT_W-1:0]               s_dat_r,
    input  logic [TGD_W-1:0]               s_tgd_r,
    input  logic                           s_ack,
    input  logic                           s_err,
    output logic [N_MASTERS-1:0]           gnt
);

    localparam int LW   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int SW   = DAT_W / 8;
    localparam int WD_W = wd_width(TIMEOUT);
    localparam bit WD_EN = (TIMEOUT > 0);
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_e           state;
    arb_state_e           state_nxt;
    logic [N_MASTERS-1:0] gnt_q;
    logic [N_MASTERS-1:0] gnt_d;
    logic [N_MASTERS-1:0] pick;
    logic [LW-1:0]        pick_idx;
    logic [LW-1:0]        last;
    logic [LW-1:0]        last_d;
    logic [WD_W-1:0]      wd_cnt;
    logic [WD_W-1:0]      wd_d;
    logic                 busy;
    logic                 own_cyc;
    logic                 own_stb;
    logic                 waiting;
    logic                 wd_fire;
    int                   own;

    assign own = int'(last);
    assign gnt = gnt_q;

    clusterv_rr_pick #(
        .N  (N_MASTERS),
        .LW (LW)
    ) u_pick (
        .req     (m_cyc),
        .last    (last),
        .gnt_nxt (pick)
    );

    // Owner status and watchdog expiry; last doubles as the owner index.
    always_comb begin
        busy    = (state == BUSY);
        own_cyc = m_cyc[last];
        own_stb = m_stb[last];
        waiting = busy && own_stb && !s_ack && !s_err;
        wd_fire = WD_EN && waiting && (wd_cnt == WD_LAST);
    end

    // Convert the one-hot pick into an index for last.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (pick[i]) begin
                pick_idx = LW'(i);
            end
        end
    end

    // Next state: grant in IDLE, hold until the owner drops cyc.
    always_comb begin
        state_nxt = state;
        gnt_d     = gnt_q;
        last_d    = last;
        unique case (state)
            IDLE: begin
                if (|m_cyc) begin
                    state_nxt = BUSY;
                    gnt_d     = pick;
                    last_d    = pick_idx;
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_nxt = IDLE;
                    gnt_d     = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_d     = '0;
            end
        endcase
    end

    // Watchdog counts unanswered strobe cycles, cleared on any end.
    always_comb begin
        wd_d = '0;
        if (WD_EN && waiting && !wd_fire) begin
            wd_d = wd_cnt + WD_W'(1);
        end
    end

    // State, grant, last owner and watchdog registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            gnt_q  <= '0;
            last   <= LW'(N_MASTERS - 1);
            wd_cnt <= '0;
        end else begin
            state  <= state_nxt;
            gnt_q  <= gnt_d;
            last   <= last_d;
            wd_cnt <= wd_d;
        end
    end

    // Owner's request onto the slave port; all zero when not busy.
    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_we    = 1'b0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_tga   = '0;
        s_tgc   = '0;
        s_tgd_w = '0;
        if (busy) begin
            s_adr   = m_adr[own*ADR_W +: ADR_W];
            s_dat_w = m_dat_w[own*DAT_W +: DAT_W];
            s_sel   = m_sel[own*SW +: SW];
            s_we    = m_we[last];
            s_cyc   = own_cyc;
            s_stb   = own_stb & ~wd_fire;
            s_tga   = m_tga[own*TGA_W +: TGA_W];
            s_tgc   = m_tgc[own*TGC_W +: TGC_W];
            s_tgd_w = m_tgd_w[own*TGD_W +: TGD_W];
        end
    end

    // Responses go only to the owner; read data is broadcast.
    always_comb begin
        m_ack   = '0;
        m_err   = '0;
        m_dat_r = s_dat_r;
        m_tgd_r = s_tgd_r;
        if (busy) begin
            m_ack[last] = s_ack;
            m_err[last] = s_err | wd_fire;
        end
    end

endmodule

// File: doc/clusterv_wb_arbiter.md
# clusterv_wb_arbiter

Round-robin Wishbone arbiter that shares one tagged Wishbone slave port (tile SRAM or peripheral fabric) among N_MASTERS tagged Wishbone masters, e.g. several `clusterv_tile` instruction/data ports. It holds the grant for the whole `cyc` assertion and steers responses back to the owner. A per-transfer watchdog terminates hung slave accesses with `err`. It sits between the tile `i_*` ports and the shared SRAM inside the cluster.

## Interface
Parameters:
- `N_MASTERS`, 4: number of requesting masters, 2..8.
- `ADR_W`, 32: address width.
- `DAT_W`, 32: data width; `sel` is DAT_W/8 bits.
- `TGA_W`, 1 / `TGC_W`, 1 / `TGD_W`, 4: address, cycle and data tag widths.
- `TIMEOUT`, 255: cycles a strobed transfer may wait for `ack`/`err`; 0 disables the watchdog.

Ports (master side packed, master i at slice i):
- Clock and reset are `clock` and `reset`; one clock, reset is synchronous and active-high.
- `clock`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `m_adr`  in  N*ADR_W; `m_dat_w` in N*DAT_W; `m_sel` in N*DAT_W/8; `m_we`, `m_cyc`, `m_stb` in N; `m_tga` in N*TGA_W; `m_tgc` in N*TGC_W; `m_tgd_w` in N*TGD_W.
- `m_dat_r`  out  DAT_W: shared read data, broadcast to all masters.
- `m_tgd_r`  out  TGD_W: shared read-data tag, broadcast to all masters.
- `m_ack`, `m_err`  out  N: per-master termination.
- `s_adr`, `s_dat_w`, `s_sel`, `s_we`, `s_cyc`, `s_stb`, `s_tga`, `s_tgc`, `s_tgd_w`  out: slave request, widths as above.
- `s_dat_r`, `s_tgd_r`, `s_ack`, `s_err`  in: slave response.
- `gnt`  out  N: one-hot current owner, for debug and perf counters.

## Operation
- States are `IDLE` and `BUSY`. Reset sets the state to `IDLE`, `gnt` to 0, `last` to N_MASTERS-1, and `wd_cnt` to 0.
- In `IDLE`, when any `m_cyc` is set, pick the first requester searching upward from `last`+1 and wrapping modulo N. Register it into `gnt` and `last`, then go to `BUSY`. With no request, stay in `IDLE` with `gnt` at 0.
- In `BUSY`, the owner's request fields are combinationally muxed onto `s_*`:
  - `s_cyc` = `m_cyc[own]`.
  - `s_stb` = `m_stb[own]` & ~`wd_fire`.
  - The owner sees `m_ack[own]` = `s_ack` and `m_err[own]` = `s_err` | `wd_fire`.
  - All other masters see `m_ack`/`m_err` at 0.
- When not `BUSY`, all `s_*` outputs are 0, except that data and address fields may hold don't-care values.
- `BUSY` returns to `IDLE` on the cycle after `m_cyc[own]` is sampled low. `gnt` clears on that transition.
- The owner may issue any number of transfers, including burst and RMW, within one `cyc`. No preemption.
- Watchdog:
  - `wd_cnt` increments each `BUSY` cycle with `s_stb` high and `s_ack`|`s_err` low.
  - It clears on any termination or when `s_stb` is low.
  - `wd_fire` = (`wd_cnt` == TIMEOUT-1) while waiting. It produces one `m_err` pulse and clears the counter.
  - Ownership is kept until the owner drops `cyc`.
- A slave `ack` and `err` in the same cycle are both forwarded. Masters must treat `err` as dominant.
- `reset` mid-transfer forces `IDLE` the next cycle. No `ack`/`err` is generated for the aborted transfer.

## Timing
- Arbitration latency: `m_cyc` first seen high in cycle t gives `gnt` and `s_cyc`/`s_stb` at t+1. The earliest `m_ack` is t+1 for a combinational slave ack; it is t+2 for the registered-ack SRAM model, which acks the cycle after `stb`.
- Release: when `m_cyc[own]` falls in cycle k, `s_cyc` falls in k (combinational). The state is `IDLE` at k+1 and the next owner is driven at k+2, giving one dead cycle between owners.
- Response path (`s_ack`/`s_err`/`s_dat_r` → `m_*`) is purely combinational with zero added latency.
- A watchdog error is asserted TIMEOUT cycles after the first unanswered strobe cycle.

## Structure
- Package `clusterv_wb_arb_pkg` holds:
  - the state enum `arb_state_e` {IDLE, BUSY};
  - the function `rr_pick(req, last)` returning the one-hot next grant;
  - a localparam for the watchdog counter width, $clog2(TIMEOUT+1).
- Sub-module `clusterv_rr_pick` is the combinational round-robin priority encoder (`req`, `last` → `gnt_nxt`). It is reusable by the cluster interrupt router.
- Request mux and response demux are inline in the arbiter.

## Test plan
- Single requester: m0 writes 0xDEADBEEF to 0x10000000 with a 1-cycle-latency slave → `s_cyc` at t+1, `m_ack[0]` at t+2, `gnt`=0001 then 0000 one cycle after `cyc` drops.
- Fairness: all 4 masters hold `cyc` continuously, each doing one read per ownership then dropping for one cycle → grant order 0,1,2,3,0,… over 12 ownerships, with no master skipped.
- Lock: m1 holds `cyc` across a 4-beat burst while m2 requests → m2 is not granted until 2 cycles after m1 drops `cyc`; m2 sees no `ack` during m1's burst.
- Watchdog: TIMEOUT=8 and the slave never acks → `m_err[own]` pulses exactly once, 8 cycles after the first `stb`, and `s_stb` is low that cycle.
- Reset mid-burst: assert `reset` during m3's second beat → next cycle `gnt`=0, all `s_*` outputs are 0, and the first post-reset request from m0 wins, since `last` resets to N-1.
- Tag/data integrity: the slave returns `tgd_r`=0xA with `dat_r`=0x12345678 → the owner sees both values in the same cycle as `ack`.
